// File: rtl/rv32_pkg.sv
// Shared register-file constants: default data width, register count,
// index width and the hardwired-zero register index.
package rv32_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one flag per register with an outstanding write, the
// issue handshake (WAW stall), pipeline flush and a running pending count.
module regfile_scoreboard #(
  parameter int NREGS    = rv32_pkg::NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rd_i,
  output logic             issue_ready_o,
  input  logic             wen_i,
  input  logic [AW-1:0]    rd_idx_i,
  input  logic             clear_i,
  output logic [NREGS-1:0] busy_o,
  output logic [CW-1:0]    pending_cnt_o
);
  import rv32_pkg::*;

  localparam logic [AW-1:0] ZIDX = AW'(REG_ZERO);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_issue;
  logic             accept;
  logic             drop;

  always_comb begin
    zero_issue    = (ZERO_REG != 0) && (issue_rd_i == ZIDX);
    issue_ready_o = !busy_q[issue_rd_i] || zero_issue;
    accept        = issue_valid_i && issue_ready_o && !clear_i && !zero_issue;
    // An accepted issue targets a non-busy bit, so a same-index writeback
    // never has a set bit to drop; the new producer keeps the bit set.
    drop          = wen_i && busy_q[rd_idx_i] && !(accept && (issue_rd_i == rd_idx_i));
    busy_d        = busy_q;
    cnt_d         = cnt_q;
    if (clear_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wen_i) begin
        busy_d[rd_idx_i] = 1'b0;
      end
      if (accept) begin
        busy_d[issue_rd_i] = 1'b1;
      end
      cnt_d = cnt_q + CW'(accept) - CW'(drop);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRPORTS combinational read ports, one write
// port, optional same-cycle write bypass and an integrated busy scoreboard.
module regfile_sb #(
  parameter int XLEN     = rv32_pkg::XLEN,
  parameter int NREGS    = rv32_pkg::NREGS,
  parameter int NRPORTS  = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [NRPORTS*AW-1:0]   rs_idx_i,
  output logic [NRPORTS*XLEN-1:0] rs_data_o,
  output logic [NRPORTS-1:0]      rs_busy_o,
  input  logic                    wen_i,
  input  logic [AW-1:0]           rd_idx_i,
  input  logic [XLEN-1:0]         rd_data_i,
  input  logic                    issue_valid_i,
  input  logic [AW-1:0]           issue_rd_i,
  output logic                    issue_ready_o,
  input  logic                    clear_i,
  output logic [NREGS-1:0]        busy_o,
  output logic [CW-1:0]           pending_cnt_o
);
  import rv32_pkg::*;

  localparam logic [AW-1:0] ZIDX = AW'(REG_ZERO);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            wr_ok;

  always_comb begin
    wr_ok = wen_i && !((ZERO_REG != 0) && (rd_idx_i == ZIDX));
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[rd_idx_i] = rd_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .wen_i         (wen_i),
    .rd_idx_i      (rd_idx_i),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
    .pending_cnt_o (pending_cnt_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRPORTS; gi++) begin : g_rport
      logic [AW-1:0] idx;
      logic          zero_hit;
      logic          byp_hit;

      always_comb begin
        idx      = rs_idx_i[gi*AW +: AW];
        zero_hit = (ZERO_REG != 0) && (idx == ZIDX);
        // A writeback in flight this cycle both supplies the data and retires the hazard.
        byp_hit  = (BYPASS != 0) && wen_i && (rd_idx_i == idx) && !zero_hit;
        if (zero_hit) begin
          rs_data_o[gi*XLEN +: XLEN] = '0;
          rs_busy_o[gi]              = 1'b0;
        end else if (byp_hit) begin
          rs_data_o[gi*XLEN +: XLEN] = rd_data_i;
          rs_busy_o[gi]              = 1'b0;
        end else begin
          rs_data_o[gi*XLEN +: XLEN] = mem_q[idx];
          rs_busy_o[gi]              = busy_o[idx];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed hazard scenarios followed by
// random traffic, all checked against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRP   = 2;
  localparam int CW    = 6;

  logic                clk_i = 1'b0;
  logic                reset_ni;
  logic [NRP*AW-1:0]   rs_idx_i;
  logic [NRP*XLEN-1:0] rs_data_o;
  logic [NRP-1:0]      rs_busy_o;
  logic                wen_i;
  logic [AW-1:0]       rd_idx_i;
  logic [XLEN-1:0]     rd_data_i;
  logic                issue_valid_i;
  logic [AW-1:0]       issue_rd_i;
  logic                issue_ready_o;
  logic                clear_i;
  logic [NREGS-1:0]    busy_o;
  logic [CW-1:0]       pending_cnt_o;

  always #5 clk_i = ~clk_i;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRP), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .rs_idx_i      (rs_idx_i),
    .rs_data_o     (rs_data_o),
    .rs_busy_o     (rs_busy_o),
    .wen_i         (wen_i),
    .rd_idx_i      (rd_idx_i),
    .rd_data_i     (rd_data_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .clear_i       (clear_i),
    .busy_o        (busy_o),
    .pending_cnt_o (pending_cnt_o)
  );

  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_busy [NREGS];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += m_busy[r] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [NREGS-1:0] m_vec();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic we, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                      input logic iv, input logic [AW-1:0] ird, input logic clr,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    logic [AW-1:0]   ridx [NRP];
    logic [XLEN-1:0] ed;
    logic            eb;
    logic            rdy;
    @(negedge clk_i);
    wen_i = we; rd_idx_i = rd; rd_data_i = d;
    issue_valid_i = iv; issue_rd_i = ird; clear_i = clr;
    rs_idx_i = {r1, r0};
    #1;
    ridx[0] = r0;
    ridx[1] = r1;
    for (int p = 0; p < NRP; p++) begin
      if (ridx[p] == 0) begin
        ed = '0; eb = 1'b0;
      end else if (we && rd == ridx[p]) begin
        ed = d; eb = 1'b0;
      end else begin
        ed = m_mem[ridx[p]]; eb = m_busy[ridx[p]];
      end
      chk($sformatf("rs_data%0d", p), 64'(rs_data_o[p*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("rs_busy%0d", p), 64'(rs_busy_o[p]), 64'(eb));
    end
    rdy = (ird == 0) || !m_busy[ird];
    chk("busy_o", 64'(busy_o), 64'(m_vec()));
    chk("pending", 64'(pending_cnt_o), 64'(m_count()));
    chk("issue_ready", 64'(issue_ready_o), 64'(rdy));
    $display("step we=%0b rd=%0d d=%h iv=%0b ird=%0d clr=%0b r0=%0d r1=%0d pend=%0d",
             we, rd, d, iv, ird, clr, r0, r1, pending_cnt_o);
    @(posedge clk_i);
    if (we && rd != 0) m_mem[rd] = d;
    if (clr) begin
      for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
    end else begin
      if (we) m_busy[rd] = 1'b0;
      if (iv && rdy && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    wen_i = 1'b0; rd_idx_i = '0; rd_data_i = '0;
    issue_valid_i = 1'b0; issue_rd_i = '0; clear_i = 1'b0;
    rs_idx_i = {5'd3, 5'd0};
    m_reset();
    #12;
    chk("rst_rs_data", 64'(rs_data_o), 64'd0);
    chk("rst_rs_busy", 64'(rs_busy_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_pending", 64'(pending_cnt_o), 64'd0);
    chk("rst_ready", 64'(issue_ready_o), 64'd1);
    @(negedge clk_i);
    reset_ni = 1'b1;

    // Bypass and hold
    step(1, 3, 32'h1337, 0, 0, 0, 3, 3);
    step(0, 3, 32'h1234, 0, 0, 0, 3, 3);
    #1 chk("x3_hold", 64'(rs_data_o[31:0]), 64'h1337);
    // x0 is hardwired
    step(1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0, 0, 0);
    #1 chk("x0_pending", 64'(pending_cnt_o), 64'd0);
    chk("x0_busy", 64'(busy_o), 64'd0);
    // WAW stall and writeback
    step(0, 0, 32'h0, 1, 5, 0, 5, 0);
    #1 chk("x5_busy", 64'(busy_o[5]), 64'd1);
    chk("x5_pend", 64'(pending_cnt_o), 64'd1);
    step(0, 0, 32'h0, 1, 5, 0, 5, 0);
    step(1, 5, 32'hAA, 0, 0, 0, 5, 5);
    #1 chk("x5_clr", 64'(busy_o[5]), 64'd0);
    chk("x5_data", 64'(rs_data_o[31:0]), 64'hAA);
    // Same-edge issue and write: new producer wins
    step(1, 7, 32'h55, 1, 7, 0, 7, 7);
    #1 chk("x7_busy", 64'(busy_o[7]), 64'd1);
    chk("x7_pend", 64'(pending_cnt_o), 64'd1);
    step(1, 7, 32'h66, 1, 8, 0, 7, 8);
    step(0, 0, 32'h0, 0, 0, 0, 7, 8);
    // Flush with simultaneous write and ignored issue
    for (int r = 1; r <= 4; r++) step(0, 0, 32'h0, 1, AW'(r), 0, 1, 2);
    step(1, 2, 32'h99, 1, 6, 1, 2, 1);
    #1 chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_pend", 64'(pending_cnt_o), 64'd0);
    chk("clr_x2", 64'(rs_data_o[31:0]), 64'h99);
    // Asynchronous reset in the middle of a cycle
    for (int r = 9; r <= 12; r++) step(1, AW'(r), 32'h100 + r, 1, AW'(r + 1), 0, AW'(r), 9);
    @(negedge clk_i);
    wen_i = 1'b0; issue_valid_i = 1'b0; rs_idx_i = {5'd10, 5'd9};
    #2 reset_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_pend", 64'(pending_cnt_o), 64'd0);
    chk("arst_data", 64'(rs_data_o), 64'd0);
    m_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;
    step(0, 0, 32'h0, 1, 9, 0, 9, 0);
    #1 chk("post_rst_x9", 64'(busy_o[9]), 64'd1);

    // Random traffic over a narrow index range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0),
           AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
